// File: rtl/aes128_encrypt_iter_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 encryptor.
package aes128_encrypt_iter_pkg;

  localparam int unsigned BLOCK_W  = 128;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned NBYTES   = 16;
  localparam int unsigned ROUND_W  = 4;
  localparam logic [3:0]  LAST_ROUND = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  // Round constants indexed by round number; unused slots are zero.
  localparam logic [7:0] RCON_TABLE [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // ShiftRows source byte for each destination byte (column-major layout).
  localparam logic [3:0] SHIFT_IDX [16] = '{
    4'd0,  4'd5,  4'd10, 4'd15,
    4'd4,  4'd9,  4'd14, 4'd3,
    4'd8,  4'd13, 4'd2,  4'd7,
    4'd12, 4'd1,  4'd6,  4'd11
  };

  // Multiply by x in GF(2^8), polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one column; col[31:24] is row 0.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes128_encrypt_iter_sbox.sv
// Forward AES S-box, purely combinational table lookup.
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] sub
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sub = SBOX[data];

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
module aes128_encrypt_iter
  import aes128_encrypt_iter_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  fsm_state_t           state;
  logic [ROUND_W-1:0]   round;
  logic [BLOCK_W-1:0]   state_reg;
  logic [BLOCK_W-1:0]   rk_reg;

  logic [BYTE_W-1:0]    sb_c [NBYTES];
  logic [BYTE_W-1:0]    sw_c [4];
  logic [BLOCK_W-1:0]   sr_c;
  logic [BLOCK_W-1:0]   mix_c;
  logic [BLOCK_W-1:0]   round_out_c;
  logic [BLOCK_W-1:0]   rk_next_c;
  logic [WORD_W-1:0]    temp_c;
  logic [WORD_W-1:0]    w0_c, w1_c, w2_c, w3_c;

  // SubBytes and ShiftRows on the state, MixColumns per column.
  for (genvar i = 0; i < 16; i++) begin : g_state_bytes
    aes_sbox u_sbox (
      .data (state_reg[127-8*i -: 8]),
      .sub  (sb_c[i])
    );
    assign sr_c[127-8*i -: 8] = sb_c[SHIFT_IDX[i]];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mix_c[127-32*c -: 32] = mix_column(sr_c[127-32*c -: 32]);
  end

  // SubWord on the last key word (bytes 12..15); RotWord is applied after substitution.
  for (genvar j = 0; j < 4; j++) begin : g_key_bytes
    aes_sbox u_sbox (
      .data (rk_reg[31-8*j -: 8]),
      .sub  (sw_c[j])
    );
  end

  assign temp_c    = {sw_c[1], sw_c[2], sw_c[3], sw_c[0]} ^ {RCON_TABLE[round], 24'h000000};
  assign w0_c      = rk_reg[127:96] ^ temp_c;
  assign w1_c      = rk_reg[95:64]  ^ w0_c;
  assign w2_c      = rk_reg[63:32]  ^ w1_c;
  assign w3_c      = rk_reg[31:0]   ^ w2_c;
  assign rk_next_c = {w0_c, w1_c, w2_c, w3_c};

  assign round_out_c = ((round == LAST_ROUND) ? sr_c : mix_c) ^ rk_next_c;

  assign out_data = state_reg;

  // Control FSM and datapath registers; handshake outputs are registered alongside state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      round     <= '0;
      state_reg <= '0;
      rk_reg    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            state_reg <= in_data ^ in_key;
            rk_reg    <= in_key;
            round     <= 4'd1;
            state     <= RUN;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          state_reg <= round_out_c;
          rk_reg    <= rk_next_c;
          if (round == LAST_ROUND) begin
            round     <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            round <= round + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          round     <= '0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
